// File: rtl/weight_loader.sv
// weight_loader
// Fills one layer's weight memory from a serial stream of parameter words.
// All convolution weights are written first, ordered k_x fastest, then k_y,
// then input map, then output map. After them come the per-output biases.
// Every accepted word becomes exactly one memory write in the following cycle.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start           - begin a load (only honoured in IDLE)
//   in_valid/in_ready/in_data - parameter stream handshake
//   weight_write, bias_write  - registered memory write strobes
//   index_in, index_out, index_k_y, index_k_x - registered memory indices
//                     (index_k_x carries the bias index on bias writes)
//   out_data        - registered memory write data
//   busy            - load in progress (LOAD_W, LOAD_B, FINISH)
//   done            - one-cycle completion pulse
module weight_loader #(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int DIM         = 1,
  parameter int DATA_SIZE   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 weight_write,
  output logic                 bias_write,
  output logic [15:0]          index_in,
  output logic [15:0]          index_out,
  output logic [15:0]          index_k_y,
  output logic [15:0]          index_k_x,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    FINISH = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [15:0] K_MAX   = 16'(DIM - 1);
  localparam logic [15:0] IN_MAX  = 16'(NUM_INPUTS - 1);
  localparam logic [15:0] OUT_MAX = 16'(NUM_OUTPUTS - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt_x;
  logic [15:0] cnt_y;
  logic [15:0] cnt_in;
  logic [15:0] cnt_out;
  logic [15:0] cnt_b;
  logic        xfer;
  logic        wrap_x;
  logic        wrap_y;
  logic        wrap_in;
  logic        last_w;
  logic        last_b;

  // Handshake and counter-boundary decode; in_ready depends on state only.
  always_comb begin
    in_ready = (state == LOAD_W) || (state == LOAD_B);
    busy     = (state == LOAD_W) || (state == LOAD_B) || (state == FINISH);
    done     = (state == DONE);
    xfer     = in_valid && in_ready;
    wrap_x   = (cnt_x == K_MAX);
    wrap_y   = (cnt_y == K_MAX);
    wrap_in  = (cnt_in == IN_MAX);
    last_w   = wrap_x && wrap_y && wrap_in && (cnt_out == OUT_MAX);
    last_b   = (cnt_b == OUT_MAX);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD_W;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD_W: begin
        if (xfer && last_w) begin
          state_next = LOAD_B;
        end else begin
          state_next = LOAD_W;
        end
      end
      LOAD_B: begin
        if (xfer && last_b) begin
          state_next = FINISH;
        end else begin
          state_next = LOAD_B;
        end
      end
      FINISH:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Weight and bias position counters; they move only on an accepted word.
  always_ff @(posedge clk) begin
    if (rst || ((state == IDLE) && start)) begin
      cnt_x   <= 16'd0;
      cnt_y   <= 16'd0;
      cnt_in  <= 16'd0;
      cnt_out <= 16'd0;
      cnt_b   <= 16'd0;
    end else if (xfer && (state == LOAD_W)) begin
      // Ripple carry: each counter advances when all faster ones wrap.
      cnt_x <= wrap_x ? 16'd0 : cnt_x + 16'd1;
      if (wrap_x) begin
        cnt_y <= wrap_y ? 16'd0 : cnt_y + 16'd1;
        if (wrap_y) begin
          cnt_in <= wrap_in ? 16'd0 : cnt_in + 16'd1;
          if (wrap_in) begin
            cnt_out <= (cnt_out == OUT_MAX) ? 16'd0 : cnt_out + 16'd1;
          end
        end
      end
    end else if (xfer && (state == LOAD_B)) begin
      cnt_b <= last_b ? 16'd0 : cnt_b + 16'd1;
    end
  end

  // Registered memory write port: strobe, indices and data one cycle after
  // the transfer; indices and data hold while no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_write <= 1'b0;
      bias_write   <= 1'b0;
      index_in     <= 16'd0;
      index_out    <= 16'd0;
      index_k_y    <= 16'd0;
      index_k_x    <= 16'd0;
      out_data     <= '0;
    end else begin
      weight_write <= xfer && (state == LOAD_W);
      bias_write   <= xfer && (state == LOAD_B);
      if (xfer) begin
        out_data <= in_data;
        if (state == LOAD_W) begin
          index_in  <= cnt_in;
          index_out <= cnt_out;
          index_k_y <= cnt_y;
          index_k_x <= cnt_x;
        end else begin
          index_in  <= 16'd0;
          index_out <= 16'd0;
          index_k_y <= 16'd0;
          index_k_x <= cnt_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

  localparam int NI   = 2;
  localparam int NO   = 3;
  localparam int D    = 2;
  localparam int NW   = NI * NO * D * D;
  localparam int TOT  = NW + NO;

  typedef struct packed {
    logic        bias;
    logic [15:0] i;
    logic [15:0] o;
    logic [15:0] y;
    logic [15:0] x;
    logic [63:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        start_b = 1'b0;
  logic        in_valid_b = 1'b0;
  logic [63:0] in_data_b = 64'd0;

  logic        in_ready_a, ww_a, bw_a, busy_a, done_a;
  logic [15:0] ii_a, io_a, iy_a, ix_a;
  logic [63:0] od_a;
  logic        in_ready_b, ww_b, bw_b, busy_b, done_b;
  logic [15:0] ii_b, io_b, iy_b, ix_b;
  logic [63:0] od_b;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t log_a[$];
  int  dones_a = 0, xfers_a = 0, strobes_a = 0;
  int  dones_b = 0;
  logic prev_xfer_a = 1'b0;
  logic prev_xfer_b = 1'b0;

  weight_loader #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .DIM(D), .DATA_SIZE(64)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .weight_write(ww_a), .bias_write(bw_a),
    .index_in(ii_a), .index_out(io_a), .index_k_y(iy_a), .index_k_x(ix_a),
    .out_data(od_a), .busy(busy_a), .done(done_a)
  );

  weight_loader #(.NUM_INPUTS(1), .NUM_OUTPUTS(1), .DIM(1), .DATA_SIZE(64)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .weight_write(ww_b), .bias_write(bw_b),
    .index_in(ii_b), .index_out(io_b), .index_k_y(iy_b), .index_k_x(ix_b),
    .out_data(od_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_wr(input string name, input wr_t act, input wr_t exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got b=%0d i=%0d o=%0d y=%0d x=%0d d=%0h expected b=%0d i=%0d o=%0d y=%0d x=%0d d=%0h",
               name, act.bias, act.i, act.o, act.y, act.x, act.d,
               exp.bias, exp.i, exp.o, exp.y, exp.x, exp.d);
    end
  endtask

  // Expected write k of a full load on dut_a.
  function automatic wr_t model_a(input int k);
    wr_t e;
    e.d = 64'(k);
    if (k < NW) begin
      e.bias = 1'b0;
      e.x = 16'(k % D);
      e.y = 16'((k / D) % D);
      e.i = 16'((k / (D * D)) % NI);
      e.o = 16'(k / (D * D * NI));
    end else begin
      e.bias = 1'b1;
      e.i = 16'd0;
      e.o = 16'd0;
      e.y = 16'd0;
      e.x = 16'(k - NW);
    end
    return e;
  endfunction

  // Monitor for dut_a: pops the scoreboard on every write strobe.
  initial forever begin
    wr_t act;
    @(negedge clk);
    if (ww_a || bw_a) begin
      strobes_a = strobes_a + 1;
      check("a_strobe_after_xfer", 64'(prev_xfer_a), 64'd1);
      check("a_single_strobe", 64'(ww_a && bw_a), 64'd0);
      act = '{bw_a, ii_a, io_a, iy_a, ix_a, od_a};
      log_a.push_back(act);
      check("a_queue_has_entry", 64'(exp_a.size() != 0), 64'd1);
      if (exp_a.size() != 0) cmp_wr("a_write", act, exp_a.pop_front());
    end
    if (done_a) dones_a = dones_a + 1;
    if (in_valid && in_ready_a) xfers_a = xfers_a + 1;
    prev_xfer_a = in_valid && in_ready_a;
  end

  // Monitor for dut_b (DIM=1, one input, one output).
  initial forever begin
    wr_t act;
    @(negedge clk);
    if (ww_b || bw_b) begin
      check("b_strobe_after_xfer", 64'(prev_xfer_b), 64'd1);
      check("b_single_strobe", 64'(ww_b && bw_b), 64'd0);
      act = '{bw_b, ii_b, io_b, iy_b, ix_b, od_b};
      check("b_queue_has_entry", 64'(exp_b.size() != 0), 64'd1);
      if (exp_b.size() != 0) cmp_wr("b_write", act, exp_b.pop_front());
    end
    if (done_b) dones_b = dones_b + 1;
    prev_xfer_b = in_valid_b && in_ready_b;
  end

  task automatic check_zero_a(input string name);
    check({name, "_ctrl"}, 64'({in_ready_a, ww_a, bw_a, busy_a, done_a}), 64'd0);
    check({name, "_idx"}, {ii_a, io_a, iy_a, ix_a}, 64'd0);
    check({name, "_data"}, od_a, 64'd0);
  endtask

  // mode 0: in_valid held; 1: in_valid toggled; 2: start pulsed after 10 words.
  task automatic run_load(input int mode, input int stop_after);
    int n, cyc, first_c, last_c, done_c;
    logic [7:0] pat;
    pat = 8'b0110_1001;
    for (int k = 0; k < TOT; k++) exp_a.push_back(model_a(k));
    log_a.delete();
    dones_a = 0; xfers_a = 0; strobes_a = 0;
    @(posedge clk); #1; start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    n = 0; cyc = 0; first_c = 0; last_c = 0;
    while (n < stop_after && cyc < 400) begin
      in_valid = (mode == 1) ? pat[3'(cyc)] : 1'b1;
      in_data  = 64'(n);
      start    = (mode == 2) && (n == 10);
      @(negedge clk);
      if (in_valid && in_ready_a) begin
        if (n == 0) first_c = cycle;
        last_c = cycle;
        n = n + 1;
      end
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("transfer_count", 64'(n), 64'(stop_after));
    if (stop_after == TOT) begin
      if (mode == 0) check("consecutive_cycles", 64'(last_c - first_c), 64'(TOT - 1));
      done_c = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 0) begin
          check("finish_busy", 64'(busy_a), 64'd1);
          check("finish_in_ready", 64'(in_ready_a), 64'd0);
        end
        if (done_a) begin
          done_c = cycle;
          check("busy_at_done", 64'(busy_a), 64'd0);
          break;
        end
      end
      check("done_latency", 64'(done_c - last_c), 64'd2);
      @(negedge clk);
      check("done_pulses", 64'(dones_a), 64'd1);
      check("strobes_eq_xfers", 64'(strobes_a), 64'(xfers_a));
      check("write_total", 64'(strobes_a), 64'(TOT));
      check("queue_drained", 64'(exp_a.size()), 64'd0);
      if (mode == 0) begin
        check("log_size", 64'(log_a.size()), 64'(TOT));
        if (log_a.size() == TOT) begin
          cmp_wr("spot_w0",  log_a[0],  '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 64'd0});
          cmp_wr("spot_w5",  log_a[5],  '{1'b0, 16'd1, 16'd0, 16'd0, 16'd1, 64'd5});
          cmp_wr("spot_w23", log_a[23], '{1'b0, 16'd1, 16'd2, 16'd1, 16'd1, 64'd23});
          cmp_wr("spot_b0",  log_a[24], '{1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 64'd24});
          cmp_wr("spot_b1",  log_a[25], '{1'b1, 16'd0, 16'd0, 16'd0, 16'd1, 64'd25});
          cmp_wr("spot_b2",  log_a[26], '{1'b1, 16'd0, 16'd0, 16'd0, 16'd2, 64'd26});
        end
      end
    end
  endtask

  initial begin
    int done_seen;
    // Reset values.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_a("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Held valid, toggled valid, ignored start pulse.
    run_load(0, TOT);
    run_load(1, TOT);
    run_load(2, TOT);

    // Reset in the middle of a load, then reload from index 0.
    run_load(0, 13);
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_zero_a("midload_reset");
    exp_a.delete();
    run_load(0, TOT);

    // Minimal configuration: one weight A, one bias B.
    exp_b.push_back('{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 64'h3FF0_0000_0000_0000});
    exp_b.push_back('{1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 64'hC008_0000_0000_0000});
    dones_b = 0;
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0; in_valid_b = 1'b1; in_data_b = 64'h3FF0_0000_0000_0000;
    @(posedge clk); #1; in_data_b = 64'hC008_0000_0000_0000;
    @(posedge clk); #1; in_valid_b = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_b) begin
        done_seen = 1;
        break;
      end
    end
    check("b_done_seen", 64'(done_seen), 64'd1);
    @(negedge clk);
    check("b_done_pulses", 64'(dones_b), 64'd1);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);

    // Idle: offered words are never accepted without start.
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(k + 100);
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready_a), 64'd0);
      check("idle_busy", 64'(busy_a), 64'd0);
      check("idle_strobes", 64'(ww_a || bw_a), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
